line_status_unit: RTL and testbench
===================================

// Module: line_status_unit
// PURPOSE
//  Parametrised line status unit for the UART register file; successor to the plain LSR latch.
//  Holds the 8-bit LSR with sticky error bits (OE/PE/FE/BI) that clear on CPU read.
//  Tracks the errored words resident in the RX FIFO to drive LSR[7].
//  Drives the receiver-line-status interrupt; sits between the RX/TX datapath and the bus decoder.
// PARAMETERS
//  FIFO_DEPTH  16     RX FIFO entries; sets the error counter range 0..FIFO_DEPTH
//  CNT_W       5      error counter width, >= clog2(FIFO_DEPTH+1)
//  LSR_RESET   8'h60  reset/flush value of LSR (THRE=1, TEMT=1)
// PORTS
//  BCLK          in   1      baud/system clock, all state on rising edge
//  RST_N         in   1      asynchronous reset, active low
//  fifo_en       in   1      1 = FIFO mode (LSR[7] active), 0 = character mode
//  ls_irq_en     in   1      IER receiver-line-status enable
//  data_ready    in   1      RBR/FIFO non-empty (level)
//  thr_empty     in   1      THR/TX FIFO empty (level)
//  tsr_empty     in   1      TSR empty (level)
//  overrun_evt   in   1      one-cycle overrun event pulse
//  parity_evt    in   1      one-cycle parity error pulse
//  framing_evt   in   1      one-cycle framing error pulse
//  break_evt     in   1      one-cycle break detect pulse
//  rx_push       in   1      word written into RX FIFO this cycle
//  rx_push_err   in   1      pushed word carries PE/FE/BI (qualified by rx_push)
//  rx_pop        in   1      word read from RX FIFO this cycle
//  rx_pop_err    in   1      popped word carried PE/FE/BI (qualified by rx_pop)
//  rx_flush      in   1      RX FIFO reset (FCR bit 1), one-cycle pulse
//  lsr_rd        in   1      one-cycle pulse: CPU reads LSR this cycle
//  LSR           out  8      line status register (registered)
//  ls_irq        out  1      line status interrupt request (registered)
//  err_count     out  CNT_W  errored words in RX FIFO (debug/visibility)
// BEHAVIOUR
//  Reset (RST_N=0, async): LSR=LSR_RESET, err_count=0, ls_irq=0; holds until RST_N rises.
//  Level bits, every edge: LSR[0]<=data_ready, LSR[5]<=thr_empty, LSR[6]<=tsr_empty (1-cycle latency).
//  Sticky bits LSR[1..4] (OE,PE,FE,BI): set on respective event pulse; remain set until lsr_rd.
//   - edge with lsr_rd=1: bit <= its event input (clear, but a same-cycle event wins -> stays 1).
//   - bus samples LSR as it stands in the lsr_rd cycle (pre-clear value); cleared value visible next cycle.
//  Error counter (FIFO mode only):
//   - inc = rx_push&rx_push_err, dec = rx_pop&rx_pop_err; inc&dec -> unchanged.
//   - saturates at FIFO_DEPTH on inc; holds at 0 on dec (no wrap either direction).
//   - rx_flush or fifo_en=0 -> err_count<=0, overriding inc/dec that cycle.
//  LSR[7] <= fifo_en & (next err_count != 0); not cleared by lsr_rd (clears only when errored words drain).
//  rx_flush also clears LSR[1..4] and LSR[7]; level bits unaffected.
//  ls_irq <= ls_irq_en & |(next LSR[4:1]); falls the cycle after the clearing lsr_rd.
//  Simultaneous all four events: all four bits set in the same edge.
//  Reset mid-operation: all sticky/counter state lost immediately; no partial clears.
// STRUCTURE
//  Shared package uart_pkg: bit indices LSR_DR,LSR_OE,LSR_PE,LSR_FE,LSR_BI,LSR_THRE,LSR_TEMT,
//   LSR_FIFOERR; constant LSR_RESET_VAL=8'h60.
//  Sub-module lsr_err_counter (CNT_W, FIFO_DEPTH): saturating up/down counter with sync clear,
//   output nonzero flag. Remainder (sticky bits, irq) flat in this module.
// TESTING
//  1 Release RST_N, idle inputs -> LSR=8'h60, ls_irq=0, err_count=0.
//  2 parity_evt pulse, ls_irq_en=1 -> next cycle LSR[2]=1, ls_irq=1; lsr_rd pulse -> bus sees
//    LSR[2]=1, next cycle LSR[2]=0, ls_irq=0.
//  3 framing_evt and lsr_rd in same cycle -> LSR[3] remains 1 after the read.
//  4 fifo_en=1: 3 pushes with err, 1 pop with err -> err_count=2, LSR[7]=1; lsr_rd -> LSR[7] stays 1;
//    2 more err pops -> err_count=0, LSR[7]=0.
//  5 err_count=FIFO_DEPTH, push_err -> stays 16; err_count=0, pop_err -> stays 0; push_err&pop_err
//    together at 5 -> stays 5.
//  6 err_count=4, OE set, rx_flush -> err_count=0, LSR[7]=0, LSR[1]=0; assert RST_N=0 mid-burst ->
//    LSR=8'h60 immediately, before next BCLK edge.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants: LSR bit positions and reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int LSR_DR      = 0;
   localparam int LSR_OE      = 1;
   localparam int LSR_PE      = 2;
   localparam int LSR_FE      = 3;
   localparam int LSR_BI      = 4;
   localparam int LSR_THRE    = 5;
   localparam int LSR_TEMT    = 6;
   localparam int LSR_FIFOERR = 7;

   localparam logic [7:0] LSR_RESET_VAL = 8'h60;

endpackage

`default_nettype wire

// File: rtl/line_status_unit_if.sv
// ============================================================================
// Module      : line_status_unit_if
// Description : Datapath/bus-side signals of the line status unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_status_unit_if #(
   parameter int CNT_W = 5
) ();

   logic             fifo_en;
   logic             ls_irq_en;
   logic             data_ready;
   logic             thr_empty;
   logic             tsr_empty;
   logic             overrun_evt;
   logic             parity_evt;
   logic             framing_evt;
   logic             break_evt;
   logic             rx_push;
   logic             rx_push_err;
   logic             rx_pop;
   logic             rx_pop_err;
   logic             rx_flush;
   logic             lsr_rd;
   logic [7:0]       LSR;
   logic             ls_irq;
   logic [CNT_W-1:0] err_count;

   modport master (
      output fifo_en, ls_irq_en, data_ready, thr_empty, tsr_empty,
             overrun_evt, parity_evt, framing_evt, break_evt,
             rx_push, rx_push_err, rx_pop, rx_pop_err, rx_flush, lsr_rd,
      input  LSR, ls_irq, err_count
   );

   modport slave (
      input  fifo_en, ls_irq_en, data_ready, thr_empty, tsr_empty,
             overrun_evt, parity_evt, framing_evt, break_evt,
             rx_push, rx_push_err, rx_pop, rx_pop_err, rx_flush, lsr_rd,
      output LSR, ls_irq, err_count
   );

endinterface

`default_nettype wire

// File: rtl/lsr_err_counter.sv
// ============================================================================
// Module      : lsr_err_counter
// Description : Saturating up/down count of errored words in the RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsr_err_counter #(
   parameter int CNT_W      = 5,
   parameter int FIFO_DEPTH = 16
) (
   input  wire logic             BCLK,
   input  wire logic             RST_N,
   input  wire logic             i_clr,
   input  wire logic             i_inc,
   input  wire logic             i_dec,
   output logic [CNT_W-1:0]      o_count,
   output logic                  o_next_nonzero
);

   localparam logic [CNT_W-1:0] c_max = CNT_W'(FIFO_DEPTH);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;

   always_comb begin
      w_count_next = r_count;
      if (i_clr) begin
         w_count_next = '0;
      end else if (i_inc && !i_dec && (r_count != c_max)) begin
         w_count_next = r_count + 1'b1;
      end else if (i_dec && !i_inc && (r_count != '0)) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_ff @(posedge BCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // LSR[7] is registered alongside the count, so it needs the next value
   assign o_next_nonzero = (w_count_next != '0);
   assign o_count        = r_count;

endmodule

`default_nettype wire

// File: rtl/line_status_unit.sv
// ============================================================================
// Module      : line_status_unit
// Description : UART LSR with sticky error bits, FIFO error tracking and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_status_unit
   import uart_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter int         CNT_W      = 5,
   parameter logic [7:0] LSR_RESET  = LSR_RESET_VAL
) (
   input  wire logic          BCLK,
   input  wire logic          RST_N,
   line_status_unit_if.slave  bus
);

   logic [7:0]       r_lsr;
   logic             r_ls_irq;
   logic [7:0]       w_lsr_next;
   logic [3:0]       w_evt;
   logic [3:0]       w_sticky_next;
   logic             w_cnt_clr;
   logic             w_cnt_nonzero_next;
   logic [CNT_W-1:0] w_count;

   assign w_evt     = {bus.break_evt, bus.framing_evt, bus.parity_evt, bus.overrun_evt};
   assign w_cnt_clr = bus.rx_flush || !bus.fifo_en;

   lsr_err_counter #(
      .CNT_W      (CNT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_err_counter (
      .BCLK           (BCLK),
      .RST_N          (RST_N),
      .i_clr          (w_cnt_clr),
      .i_inc          (bus.rx_push && bus.rx_push_err),
      .i_dec          (bus.rx_pop && bus.rx_pop_err),
      .o_count        (w_count),
      .o_next_nonzero (w_cnt_nonzero_next)
   );

   always_comb begin
      w_sticky_next = r_lsr[LSR_BI:LSR_OE] | w_evt;
      // A read clears the sticky bits, yet an event in the read cycle still lands
      if (bus.rx_flush) begin
         w_sticky_next = '0;
      end else if (bus.lsr_rd) begin
         w_sticky_next = w_evt;
      end

      w_lsr_next                 = r_lsr;
      w_lsr_next[LSR_DR]         = bus.data_ready;
      w_lsr_next[LSR_BI:LSR_OE]  = w_sticky_next;
      w_lsr_next[LSR_THRE]       = bus.thr_empty;
      w_lsr_next[LSR_TEMT]       = bus.tsr_empty;
      w_lsr_next[LSR_FIFOERR]    = bus.fifo_en && w_cnt_nonzero_next;
   end

   always_ff @(posedge BCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_lsr    <= LSR_RESET;
         r_ls_irq <= 1'b0;
      end else begin
         r_lsr    <= w_lsr_next;
         r_ls_irq <= bus.ls_irq_en && (|w_sticky_next);
      end
   end

   assign bus.LSR       = r_lsr;
   assign bus.ls_irq    = r_ls_irq;
   assign bus.err_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_line_status_unit.sv
// ============================================================================
// Module      : tb_line_status_unit
// Description : Directed plus random checks of line_status_unit against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_status_unit;

   localparam int c_depth = 16;
   localparam int c_cnt_w = 5;

   logic BCLK;
   logic RST_N;

   line_status_unit_if #(.CNT_W(c_cnt_w)) bus ();

   line_status_unit #(
      .FIFO_DEPTH (c_depth),
      .CNT_W      (c_cnt_w),
      .LSR_RESET  (8'h60)
   ) dut (
      .BCLK  (BCLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial BCLK = 1'b0;
   always #5 BCLK = ~BCLK;

   int total = 0;
   int bad   = 0;

   // reference state: booleans and an integer count
   bit m_dr, m_thre, m_temt, m_oe, m_pe, m_fe, m_bi, m_irq;
   int m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_lsr();
      return {(bus.fifo_en && m_cnt != 0) ? 1'b1 : 1'b0, m_temt, m_thre, m_bi, m_fe, m_pe, m_oe, m_dr};
   endfunction

   task automatic model_reset();
      m_dr = 0; m_thre = 1; m_temt = 1;
      m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0;
      m_irq = 0; m_cnt = 0;
   endtask

   bit m_b7;

   task automatic model_edge();
      bit push_e, pop_e;
      m_dr   = bus.data_ready;
      m_thre = bus.thr_empty;
      m_temt = bus.tsr_empty;
      if (bus.rx_flush) begin
         m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0;
      end else if (bus.lsr_rd) begin
         m_oe = bus.overrun_evt; m_pe = bus.parity_evt;
         m_fe = bus.framing_evt; m_bi = bus.break_evt;
      end else begin
         m_oe |= bus.overrun_evt; m_pe |= bus.parity_evt;
         m_fe |= bus.framing_evt; m_bi |= bus.break_evt;
      end
      push_e = bus.rx_push && bus.rx_push_err;
      pop_e  = bus.rx_pop && bus.rx_pop_err;
      if (bus.rx_flush || !bus.fifo_en) m_cnt = 0;
      else if (push_e && !pop_e)        m_cnt = (m_cnt < c_depth) ? m_cnt + 1 : c_depth;
      else if (pop_e && !push_e)        m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      m_b7  = bus.fifo_en && (m_cnt != 0);
      m_irq = bus.ls_irq_en && (m_oe || m_pe || m_fe || m_bi);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_lsr"}, bus.LSR, {m_b7, m_temt, m_thre, m_bi, m_fe, m_pe, m_oe, m_dr});
      chk({tag, "_irq"}, bus.ls_irq, m_irq);
      chk({tag, "_cnt"}, bus.err_count, m_cnt);
   endtask

   task automatic pulses_off();
      bus.overrun_evt = 0; bus.parity_evt = 0; bus.framing_evt = 0; bus.break_evt = 0;
      bus.rx_push = 0; bus.rx_push_err = 0; bus.rx_pop = 0; bus.rx_pop_err = 0;
      bus.rx_flush = 0; bus.lsr_rd = 0;
   endtask

   // apply current inputs for one edge, then check and drop pulses
   task automatic step(input string tag);
      model_edge();
      @(posedge BCLK);
      #1;
      check_all(tag);
      pulses_off();
   endtask

   initial begin
      RST_N = 1'b0;
      bus.fifo_en = 0; bus.ls_irq_en = 0;
      bus.data_ready = 0; bus.thr_empty = 1; bus.tsr_empty = 1;
      pulses_off();
      model_reset();
      m_b7 = 0;
      repeat (3) @(posedge BCLK);
      #1;
      RST_N = 1'b1;
      chk("t1_lsr", bus.LSR, 8'h60);
      chk("t1_irq", bus.ls_irq, 0);
      chk("t1_cnt", bus.err_count, 0);
      step("t1_idle");

      // parity event raises PE and irq; read sees pre-clear value
      bus.ls_irq_en = 1; bus.parity_evt = 1;
      step("t2_set");
      chk("t2_pe", bus.LSR[2], 1);
      chk("t2_irq", bus.ls_irq, 1);
      bus.lsr_rd = 1;
      chk("t2_bus_pre", bus.LSR[2], 1);
      step("t2_rd");
      chk("t2_pe_clr", bus.LSR[2], 0);
      chk("t2_irq_clr", bus.ls_irq, 0);

      // event in the read cycle survives the read
      bus.framing_evt = 1; bus.lsr_rd = 1;
      step("t3");
      chk("t3_fe", bus.LSR[3], 1);
      bus.lsr_rd = 1;
      step("t3_rd2");

      // FIFO error tracking
      bus.fifo_en = 1;
      repeat (3) begin bus.rx_push = 1; bus.rx_push_err = 1; step("t4_push"); end
      bus.rx_pop = 1; bus.rx_pop_err = 1; step("t4_pop");
      chk("t4_cnt2", bus.err_count, 2);
      chk("t4_b7", bus.LSR[7], 1);
      bus.lsr_rd = 1; step("t4_rd");
      chk("t4_b7_rd", bus.LSR[7], 1);
      repeat (2) begin bus.rx_pop = 1; bus.rx_pop_err = 1; step("t4_drain"); end
      chk("t4_cnt0", bus.err_count, 0);
      chk("t4_b7_0", bus.LSR[7], 0);

      // saturation at both ends, and inc with dec
      repeat (c_depth + 2) begin bus.rx_push = 1; bus.rx_push_err = 1; step("t5_up"); end
      chk("t5_sat", bus.err_count, c_depth);
      repeat (c_depth + 2) begin bus.rx_pop = 1; bus.rx_pop_err = 1; step("t5_dn"); end
      chk("t5_zero", bus.err_count, 0);
      repeat (5) begin bus.rx_push = 1; bus.rx_push_err = 1; step("t5_to5"); end
      bus.rx_push = 1; bus.rx_push_err = 1; bus.rx_pop = 1; bus.rx_pop_err = 1;
      step("t5_both");
      chk("t5_hold", bus.err_count, 5);
      bus.rx_pop = 1; bus.rx_pop_err = 1; step("t5_to4");

      // flush clears count, FIFO error and sticky bits
      bus.overrun_evt = 1; step("t6_oe");
      chk("t6_oe_set", bus.LSR[1], 1);
      bus.rx_flush = 1; step("t6_flush");
      chk("t6_cnt", bus.err_count, 0);
      chk("t6_b7", bus.LSR[7], 0);
      chk("t6_oe", bus.LSR[1], 0);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         bus.fifo_en     = ($urandom_range(0, 24) != 0);
         bus.ls_irq_en   = ($urandom_range(0, 3) != 0);
         bus.data_ready  = $urandom_range(0, 1);
         bus.thr_empty   = $urandom_range(0, 1);
         bus.tsr_empty   = $urandom_range(0, 1);
         bus.overrun_evt = ($urandom_range(0, 9) == 0);
         bus.parity_evt  = ($urandom_range(0, 9) == 0);
         bus.framing_evt = ($urandom_range(0, 9) == 0);
         bus.break_evt   = ($urandom_range(0, 9) == 0);
         bus.rx_push     = ($urandom_range(0, 1) == 0);
         bus.rx_push_err = ($urandom_range(0, 1) == 0);
         bus.rx_pop      = ($urandom_range(0, 2) == 0);
         bus.rx_pop_err  = ($urandom_range(0, 1) == 0);
         bus.rx_flush    = ($urandom_range(0, 79) == 0);
         bus.lsr_rd      = ($urandom_range(0, 5) == 0);
         step("rnd");
      end

      // asynchronous reset mid-burst takes effect before the next edge
      bus.fifo_en = 1; bus.ls_irq_en = 1;
      bus.break_evt = 1; bus.rx_push = 1; bus.rx_push_err = 1;
      step("t6_pre");
      bus.rx_push = 1; bus.rx_push_err = 1;
      #2;
      RST_N = 1'b0;
      #1;
      chk("t6_rst_lsr", bus.LSR, 8'h60);
      chk("t6_rst_irq", bus.ls_irq, 0);
      chk("t6_rst_cnt", bus.err_count, 0);
      pulses_off();
      model_reset();
      m_b7 = 0;
      @(posedge BCLK);
      #1;
      chk("t6_rst_hold", bus.LSR, 8'h60);
      RST_N = 1'b1;
      bus.data_ready = 0; bus.thr_empty = 1; bus.tsr_empty = 1;
      step("t6_post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
